// File: rtl/pattern_acq_ctrl_pkg.sv
// pattern_acq_ctrl_pkg: state encoding and default timing constants for the projector sequencer
package pattern_acq_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, ARM, WAIT_STB, READOUT, DONE, ERR} state_t;
  localparam int TIMER_W = 24;
  localparam int DEF_NUM_FRAMES = 480;
  localparam logic [15:0] DEF_READOUT_CYC = 16'd50000;
  localparam logic [TIMER_W-1:0] DEF_TIMEOUT_CYC = 24'd2000000;
  localparam int DEF_CNT_W = 16;
endpackage

// File: rtl/pattern_acq_ctrl_if.sv
// pattern_acq_ctrl_if: control/status and projector handshake bundle
interface pattern_acq_ctrl_if #(parameter int CNT_W = 16);
  logic start;
  logic abort;
  logic strobe_in;
  logic ack_in;
  logic trig_out;
  logic frame_rdy;
  logic busy;
  logic done;
  logic err;
  logic ovr;
  logic [CNT_W-1:0] frame_cnt;
  modport master (
    output start, abort, strobe_in, ack_in,
    input  trig_out, frame_rdy, busy, done, err, ovr, frame_cnt
  );
  modport slave (
    input  start, abort, strobe_in, ack_in,
    output trig_out, frame_rdy, busy, done, err, ovr, frame_cnt
  );
endinterface

// File: rtl/pattern_acq_ctrl_sync_edge.sv
// sync_edge: 2-FF synchronizer with a registered rising-edge detector
module sync_edge (
  input  logic clk_25,
  input  logic reset_n,
  input  logic async_in,
  output logic level,
  output logic rise
);
  logic s1, s2, s3;
  // two metastability stages, one history stage, and the registered edge flag
  always_ff @(posedge clk_25)
    if (!reset_n) {s1, s2, s3, rise} <= '0;
    else {s1, s2, s3, rise} <= {async_in, s1, s2, s2 & ~s3};
  assign level = s2;
endmodule

// File: rtl/pattern_acq_ctrl.sv
// pattern_acq_ctrl: steps the structured-light projector through one fringe-pattern acquisition
module pattern_acq_ctrl
  import pattern_acq_ctrl_pkg::*;
#(
  parameter int NUM_FRAMES = DEF_NUM_FRAMES,
  parameter logic [15:0] READOUT_CYC = DEF_READOUT_CYC,
  parameter logic [TIMER_W-1:0] TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int CNT_W = DEF_CNT_W
) (
  input logic clk_25,
  input logic reset_n,
  pattern_acq_ctrl_if.slave bus
);
  localparam logic [TIMER_W-1:0] RO_LAST = TIMER_W'(READOUT_CYC) - TIMER_W'(1);
  localparam logic [TIMER_W-1:0] TO_LAST = TIMEOUT_CYC - TIMER_W'(1);
  localparam logic [CNT_W-1:0] NF = CNT_W'(NUM_FRAMES);
  state_t state, state_n;
  logic [TIMER_W-1:0] timer, timer_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic err_n, ovr_n, tmo;
  logic act_q, rdy_q, done_q, err_q, ovr_q;
  logic stb_rise, stb_level, ack_rise, ack_level, unused_sync;

  sync_edge u_stb (.clk_25(clk_25), .reset_n(reset_n), .async_in(bus.strobe_in), .level(stb_level), .rise(stb_rise));
  sync_edge u_ack (.clk_25(clk_25), .reset_n(reset_n), .async_in(bus.ack_in), .level(ack_level), .rise(ack_rise));
  assign unused_sync = stb_level ^ ack_rise;

  assign tmo = timer == TO_LAST;

  // next state and counter/flag updates; abort overrides everything and freezes frame_cnt
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    err_n = err_q;
    ovr_n = ovr_q;
    if (bus.abort) state_n = IDLE;
    else
      case (state)
        IDLE: if (bus.start) begin
          state_n = ARM;
          cnt_n = '0;
          err_n = 1'b0;
          ovr_n = 1'b0;
        end
        ARM: state_n = ack_level ? WAIT_STB : tmo ? ERR : ARM;
        WAIT_STB: begin
          state_n = stb_rise ? READOUT : tmo ? ERR : WAIT_STB;
          cnt_n = stb_rise ? (&cnt ? cnt : cnt + CNT_W'(1)) : cnt;
        end
        READOUT: begin
          ovr_n = ovr_q | stb_rise;
          state_n = (timer != RO_LAST) ? READOUT : (cnt == NF) ? DONE : WAIT_STB;
        end
        default: state_n = IDLE;
      endcase
    timer_n = (state_n != state) ? '0 : (&timer ? timer : timer + TIMER_W'(1));
  end

  // state, timer, frame count and registered projector/status outputs
  always_ff @(posedge clk_25)
    if (!reset_n) begin
      state <= IDLE;
      timer <= '0;
      cnt <= '0;
      {act_q, rdy_q, done_q, err_q, ovr_q} <= '0;
    end else begin
      state <= state_n;
      timer <= timer_n;
      cnt <= cnt_n;
      act_q <= state_n inside {ARM, WAIT_STB, READOUT};
      rdy_q <= state_n inside {ARM, WAIT_STB};
      done_q <= state_n == DONE;
      err_q <= err_n | (state_n == ERR);
      ovr_q <= ovr_n;
    end

  assign bus.trig_out = act_q;
  assign bus.busy = act_q;
  assign bus.frame_rdy = rdy_q;
  assign bus.done = done_q;
  assign bus.err = err_q;
  assign bus.ovr = ovr_q;
  assign bus.frame_cnt = cnt;
endmodule

// File: tb/tb_pattern_acq_ctrl.sv
// tb_pattern_acq_ctrl: randomized scenario bench for the projector acquisition sequencer
module tb_pattern_acq_ctrl;
  localparam int NF = 4;
  localparam int RC = 10;
  localparam int TO = 200;
  logic clk_25 = 1'b0;
  logic reset_n = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  int done_seen = 0;

  pattern_acq_ctrl_if #(.CNT_W(16)) bus();
  pattern_acq_ctrl #(.NUM_FRAMES(NF), .READOUT_CYC(16'(RC)), .TIMEOUT_CYC(24'(TO)), .CNT_W(16)) dut (
    .clk_25(clk_25), .reset_n(reset_n), .bus(bus));

  always #20 clk_25 = ~clk_25;
  always @(posedge clk_25) if (bus.done === 1'b1) done_seen++;

  task automatic tick(int n = 1);
    repeat (n) @(negedge clk_25);
  endtask

  task automatic start_run(string tag);
    bus.ack_in = 0;
    tick(3);
    bus.start = 1;
    tick();
    bus.start = 0;
    vectors++;
    if ({bus.busy, bus.trig_out, bus.frame_rdy, bus.err, bus.ovr} !== 5'b11100 || bus.frame_cnt !== 16'd0) begin
      miscompares++;
      $display("FAIL %s start: busy/trig/rdy/err/ovr=%b cnt=%0d, want 11100 cnt=0", tag,
               {bus.busy, bus.trig_out, bus.frame_rdy, bus.err, bus.ovr}, bus.frame_cnt);
    end
    tick(4);
    bus.ack_in = 1;
    tick(3 + $urandom_range(0, 5));
  endtask

  // one strobe; expect readout to start with exp_cnt, last exactly RC cycles, end with done if last
  task automatic run_frame(int exp_cnt, bit last, bit inj, bit exp_ovr, string tag);
    int n = 0;
    int w = 0;
    tick($urandom_range(0, 25));
    bus.strobe_in = 1;
    tick($urandom_range(1, 3));
    bus.strobe_in = 0;
    while (bus.frame_rdy === 1'b1 && n < 20) begin
      tick();
      n++;
    end
    vectors++;
    if (bus.frame_rdy !== 1'b0 || bus.frame_cnt !== 16'(exp_cnt)) begin
      miscompares++;
      $display("FAIL %s readout start: frame_rdy=%b cnt=%0d, want 0 cnt=%0d", tag, bus.frame_rdy, bus.frame_cnt, exp_cnt);
    end
    while (bus.frame_rdy === 1'b0 && bus.done !== 1'b1 && w < 100) begin
      w++;
      if (inj && w == 5) bus.strobe_in = 1;
      if (inj && w == 6) bus.strobe_in = 0;
      tick();
    end
    vectors++;
    if (w != RC || bus.done !== last || bus.frame_cnt !== 16'(exp_cnt) || bus.ovr !== exp_ovr) begin
      miscompares++;
      $display("FAIL %s readout end: width=%0d done=%b cnt=%0d ovr=%b, want %0d %b %0d %b", tag,
               w, bus.done, bus.frame_cnt, bus.ovr, RC, last, exp_cnt, exp_ovr);
    end
  endtask

  task automatic test_reset();
    {bus.start, bus.abort, bus.strobe_in, bus.ack_in} = '0;
    reset_n = 0;
    tick(3);
    vectors++;
    if ({bus.trig_out, bus.frame_rdy, bus.busy, bus.done, bus.err, bus.ovr} !== 6'b0 || bus.frame_cnt !== 16'd0) begin
      miscompares++;
      $display("FAIL reset: outs=%b cnt=%0d, want 0", {bus.trig_out, bus.frame_rdy, bus.busy, bus.done, bus.err, bus.ovr}, bus.frame_cnt);
    end
    reset_n = 1;
    tick(3);
    vectors++;
    if ({bus.trig_out, bus.frame_rdy, bus.busy, bus.done, bus.err, bus.ovr} !== 6'b0) begin
      miscompares++;
      $display("FAIL idle after reset: outs=%b, want 0", {bus.trig_out, bus.frame_rdy, bus.busy, bus.done, bus.err, bus.ovr});
    end
  endtask

  task automatic test_normal();
    int d0 = done_seen;
    start_run("normal");
    for (int i = 1; i <= NF; i++) run_frame(i, i == NF, 1'b0, 1'b0, "normal");
    tick();
    vectors++;
    if ({bus.done, bus.trig_out, bus.busy, bus.err, bus.ovr} !== 5'b0 || bus.frame_cnt !== 16'(NF) || done_seen - d0 != 1) begin
      miscompares++;
      $display("FAIL normal end: done/trig/busy/err/ovr=%b cnt=%0d pulses=%0d, want 0 cnt=%0d pulses=1",
               {bus.done, bus.trig_out, bus.busy, bus.err, bus.ovr}, bus.frame_cnt, done_seen - d0, NF);
    end
  endtask

  task automatic test_start_abort();
    bus.ack_in = 0;
    tick(3);
    bus.start = 1;
    bus.abort = 1;
    tick();
    {bus.start, bus.abort} = '0;
    tick(2);
    vectors++;
    if ({bus.busy, bus.trig_out, bus.frame_rdy} !== 3'b0) begin
      miscompares++;
      $display("FAIL start+abort: busy/trig/rdy=%b, want 000", {bus.busy, bus.trig_out, bus.frame_rdy});
    end
    start_run("busy_start");
    run_frame(1, 1'b0, 1'b0, 1'b0, "busy_start");
    tick(2);
    bus.start = 1;
    tick();
    bus.start = 0;
    tick();
    vectors++;
    if ({bus.busy, bus.frame_rdy} !== 2'b11 || bus.frame_cnt !== 16'd1) begin
      miscompares++;
      $display("FAIL start while busy: busy/rdy=%b cnt=%0d, want 11 cnt=1", {bus.busy, bus.frame_rdy}, bus.frame_cnt);
    end
    for (int i = 2; i <= NF; i++) run_frame(i, i == NF, 1'b0, 1'b0, "busy_start");
    tick();
  endtask

  task automatic test_timeout();
    int n = 1;
    bus.ack_in = 0;
    tick(3);
    bus.start = 1;
    tick();
    bus.start = 0;
    while (bus.err !== 1'b1 && n < 2 * TO) begin
      tick();
      n++;
    end
    vectors++;
    if (n < TO - 2 || n > TO + 2 || bus.trig_out !== 1'b0 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL arm timeout: err after %0d cycles trig=%b busy=%b, want ~%0d 0 0", n, bus.trig_out, bus.busy, TO);
    end
    tick(3);
    bus.start = 1;
    tick();
    bus.start = 0;
    vectors++;
    if (bus.err !== 1'b0 || bus.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL err clear on start: err=%b busy=%b, want 0 1", bus.err, bus.busy);
    end
    tick(4);
    bus.ack_in = 1;
    n = 0;
    while (bus.err !== 1'b1 && n < 2 * TO) begin
      tick();
      n++;
      if (n == TO - 10 && bus.frame_rdy !== 1'b1) begin
        vectors++;
        miscompares++;
        $display("FAIL wait_stb hold: frame_rdy=%b, want 1", bus.frame_rdy);
      end
    end
    vectors++;
    if (n < TO - 1 || n > TO + 5 || bus.trig_out !== 1'b0 || bus.frame_rdy !== 1'b0 || bus.frame_cnt !== 16'd0) begin
      miscompares++;
      $display("FAIL wait timeout: err after %0d cycles trig=%b rdy=%b cnt=%0d, want ~%0d 0 0 0",
               n, bus.trig_out, bus.frame_rdy, bus.frame_cnt, TO + 2);
    end
    tick(2);
    vectors++;
    if (bus.err !== 1'b1 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL err sticky: err=%b busy=%b, want 1 0", bus.err, bus.busy);
    end
  endtask

  task automatic test_overrun();
    int d0 = done_seen;
    start_run("overrun");
    for (int i = 1; i <= NF; i++) run_frame(i, i == NF, i == 2, i >= 2, "overrun");
    tick();
    vectors++;
    if (bus.ovr !== 1'b1 || bus.frame_cnt !== 16'(NF) || done_seen - d0 != 1 || bus.err !== 1'b0) begin
      miscompares++;
      $display("FAIL overrun end: ovr=%b cnt=%0d pulses=%0d err=%b, want 1 %0d 1 0", bus.ovr, bus.frame_cnt, done_seen - d0, bus.err, NF);
    end
  endtask

  task automatic test_abort();
    int d0;
    int n = 0;
    start_run("abort");
    run_frame(1, 1'b0, 1'b0, 1'b0, "abort");
    d0 = done_seen;
    bus.strobe_in = 1;
    tick(2);
    bus.strobe_in = 0;
    while (bus.frame_rdy === 1'b1 && n < 20) begin
      tick();
      n++;
    end
    tick(3);
    bus.abort = 1;
    tick();
    bus.abort = 0;
    vectors++;
    if ({bus.busy, bus.trig_out, bus.frame_rdy, bus.done} !== 4'b0 || bus.frame_cnt !== 16'd2) begin
      miscompares++;
      $display("FAIL abort: busy/trig/rdy/done=%b cnt=%0d, want 0000 cnt=2", {bus.busy, bus.trig_out, bus.frame_rdy, bus.done}, bus.frame_cnt);
    end
    tick(RC + 5);
    vectors++;
    if (done_seen != d0 || bus.busy !== 1'b0 || bus.frame_cnt !== 16'd2) begin
      miscompares++;
      $display("FAIL after abort: pulses=%0d busy=%b cnt=%0d, want 0 0 2", done_seen - d0, bus.busy, bus.frame_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int d0;
    start_run("reset_mid");
    for (int i = 1; i <= 3; i++) run_frame(i, 1'b0, i == 1, 1'b1, "reset_mid");
    tick(2);
    reset_n = 0;
    bus.ack_in = 0;
    tick();
    reset_n = 1;
    vectors++;
    if ({bus.trig_out, bus.frame_rdy, bus.busy, bus.done, bus.err, bus.ovr} !== 6'b0 || bus.frame_cnt !== 16'd0) begin
      miscompares++;
      $display("FAIL mid-run reset: outs=%b cnt=%0d, want 0", {bus.trig_out, bus.frame_rdy, bus.busy, bus.done, bus.err, bus.ovr}, bus.frame_cnt);
    end
    d0 = done_seen;
    start_run("after_reset");
    for (int i = 1; i <= NF; i++) run_frame(i, i == NF, 1'b0, 1'b0, "after_reset");
    tick();
    vectors++;
    if (done_seen - d0 != 1 || bus.frame_cnt !== 16'(NF)) begin
      miscompares++;
      $display("FAIL after reset run: pulses=%0d cnt=%0d, want 1 %0d", done_seen - d0, bus.frame_cnt, NF);
    end
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 3; r++) begin
      bit exp_ovr = 1'b0;
      int d0 = done_seen;
      start_run("b2b");
      for (int i = 1; i <= NF; i++) begin
        bit inj = $urandom_range(0, 2) == 0;
        exp_ovr |= inj;
        run_frame(i, i == NF, inj, exp_ovr, "b2b");
      end
      tick();
      vectors++;
      if (done_seen - d0 != 1 || bus.ovr !== exp_ovr || bus.busy !== 1'b0) begin
        miscompares++;
        $display("FAIL b2b run %0d: pulses=%0d ovr=%b busy=%b, want 1 %b 0", r, done_seen - d0, bus.ovr, bus.busy, exp_ovr);
      end
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_start_abort();
    test_timeout();
    test_overrun();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #(40 * 40000);
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end
endmodule
